// File: rtl/gol_pkg.sv
// gol_pkg: Game of Life rule constants and cell indexing shared by the engine and its cells
package gol_pkg;
  localparam int BIRTH_CNT = 3;
  localparam int SURV_LO = 2;
  localparam int SURV_HI = 3;
  localparam int CNT_W = 4;
  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction
endpackage

// File: rtl/gol_cell.sv
// gol_cell: counts eight neighbours and applies the B3/S23 rule to produce one cell's next state
module gol_cell
  import gol_pkg::*;
(
  input  logic       alive,
  input  logic [7:0] nb,
  output logic       nxt
);
  logic [CNT_W-1:0] cnt;
  // popcount of live neighbours, then birth/survival decision
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + CNT_W'(nb[i]);
    nxt = (cnt == CNT_W'(BIRTH_CNT)) || (alive && cnt >= CNT_W'(SURV_LO) && cnt <= CNT_W'(SURV_HI));
  end
endmodule

// File: rtl/gol_engine.sv
// gol_engine: ROWS x COLS Life grid with generation counter, stability/period-2 detection and auto-halt
module gol_engine
  import gol_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int WRAP = 0,
  parameter int STABLE_N = 16,
  parameter int GEN_W = 16,
  parameter int AUTO_HALT = 1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] d,
  input  logic                 run,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] q,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 stable,
  output logic                 osc2,
  output logic                 all_dead,
  output logic                 halted
);
  localparam int N = ROWS * COLS;
  if (ROWS < 3 || COLS < 3) begin : g_bad_dim
    $error("gol_engine: ROWS and COLS must be >= 3");
  end
  if (STABLE_N < 1 || STABLE_N > 255) begin : g_bad_stable
    $error("gol_engine: STABLE_N must be in 1..255");
  end
  logic [N-1:0] hist, nxt;
  logic         hist_valid, adv, same, stable_nx;
  logic [7:0]   same_cnt, same_nx;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nb;
      for (genvar k = 0; k < 9; k++) begin : g_nb
        if (k != 4) begin : g_live
          localparam int RR = r + k / 3 - 1;
          localparam int CC = c + k % 3 - 1;
          localparam int RW = (RR + ROWS) % ROWS;
          localparam int CW = (CC + COLS) % COLS;
          localparam bit IN = RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS;
          localparam int J = k < 4 ? k : k - 1;
          if (WRAP != 0 || IN) begin : g_on
            assign nb[J] = q[idx(RW, CW, COLS)];
          end else begin : g_off
            assign nb[J] = 1'b0;
          end
        end
      end
      gol_cell u_cell (
        .alive(q[idx(r, c, COLS)]),
        .nb   (nb),
        .nxt  (nxt[idx(r, c, COLS)])
      );
    end
  end
  assign adv = !load && !halted && (run || step);
  assign same = nxt == q;
  assign same_nx = same ? (same_cnt == 8'hFF ? same_cnt : same_cnt + 8'd1) : 8'd0;
  assign stable_nx = same_nx >= 8'(STABLE_N);
  assign all_dead = ~|q;
  // grid, history and convergence state: reset, then load, then advance, otherwise hold
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      q <= '0;
      hist <= '0;
      hist_valid <= 1'b0;
      gen_count <= '0;
      same_cnt <= '0;
      stable <= 1'b0;
      osc2 <= 1'b0;
      halted <= 1'b0;
    end else if (load) begin
      q <= d;
      hist_valid <= 1'b0;
      gen_count <= '0;
      same_cnt <= '0;
      stable <= 1'b0;
      osc2 <= 1'b0;
      halted <= 1'b0;
    end else if (adv) begin
      q <= nxt;
      hist <= q;
      hist_valid <= 1'b1;
      gen_count <= &gen_count ? gen_count : gen_count + 1'b1;
      same_cnt <= same_nx;
      stable <= stable_nx;
      osc2 <= hist_valid && nxt == hist && !same;
      halted <= (AUTO_HALT != 0) && stable_nx;
    end
  end
endmodule

// File: doc/gol_engine.md
Name: gol_engine

Overview:
- Parametrised Conway Game of Life engine: holds a ROWS x COLS cell grid, advances one generation per enabled clock, reports generation count and convergence status.
- Generalises the fixed 16x16 dead-edge grid:
  - rectangular size;
  - selectable toroidal wrap;
  - single-step control;
  - on-chip stability and period-2 oscillator detection;
  - optional auto-halt on convergence.
- Sits between the pattern loader (load/d) and the host-side logger, which reads q per generation.

Parameters:
- ROWS, 16, grid rows; must be >= 3 (elaboration error otherwise).
- COLS, 16, grid columns; must be >= 3 (elaboration error otherwise).
- WRAP, 0, 0 = cells outside the grid are dead; 1 = toroidal neighbour wrap.
- STABLE_N, 16, consecutive unchanged generations required to assert stable; range 1..255.
- GEN_W, 16, width of the generation counter.
- AUTO_HALT, 1, 1 = stop advancing once stable asserts.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- areset  in  1  asynchronous, active-high reset.
- load  in  1  synchronous load of d into the grid; highest priority.
- d  in  ROWS*COLS  initial grid; cell (r,c) = bit r*COLS+c.
- run  in  1  free-run enable: advance every cycle while high.
- step  in  1  single-generation advance request, sampled each cycle.
- q  out  ROWS*COLS  current grid, registered; same bit mapping as d.
- gen_count  out  GEN_W  generations since last load, saturating.
- stable  out  1  grid unchanged for >= STABLE_N consecutive advances.
- osc2  out  1  last advance reproduced the grid of two generations ago (period-2 oscillation).
- all_dead  out  1  q == 0; combinational from the q register, no extra latency.
- halted  out  1  auto-halt engaged.

Behaviour:
- Reset (async, areset=1): q=0, hist=0, hist_valid=0, gen_count=0, same_cnt=0, stable=0, osc2=0, halted=0. Takes effect immediately, including mid-run.
- Rule B3/S23:
  - next(r,c) = 1 if the live-neighbour count is 3;
  - or if the count is 2 and the cell is currently live;
  - else 0.
- Neighbour indexing:
  - 8 neighbours per cell.
  - WRAP=1: row/column indices taken modulo ROWS/COLS.
  - WRAP=0: out-of-range neighbours count as 0.
- Priority per cycle: areset > load > advance > hold.
- Load cycle:
  - q<=d, gen_count<=0, same_cnt<=0, stable<=0, osc2<=0, halted<=0, hist_valid<=0.
  - run/step ignored that cycle.
- advance = !load && !halted && (run || step). run and step together give one advance, not two.
- On advance (all in the same edge; 1-cycle latency from advance to updated q):
  - q<=next(q), hist<=q, hist_valid<=1.
  - gen_count<=gen_count+1, saturating at all-ones.
  - If next==q: same_cnt<=min(same_cnt+1,255); else same_cnt<=0.
  - stable<=(new same_cnt >= STABLE_N).
  - osc2<=hist_valid && next==hist && next!=q.
  - If AUTO_HALT and new stable=1: halted<=1 on the same edge.
- Hold (no advance): all registers keep their values, including stable and osc2.
- halted clears only on load or areset.
- All-dead grid: next==q, so it counts toward stable like any still life.

Decomposition:
- Package gol_pkg:
  - BIRTH_CNT=3, SURV_LO=2, SURV_HI=3;
  - neighbour-count width constant (4 bits);
  - cell-index function idx(r,c)=r*COLS+c.
- Sub-module gol_cell: combinational 8-input popcount plus rule, producing next state for one cell; instantiated ROWS*COLS times by a generate loop.
- gol_engine owns all registers, wrap/edge neighbour wiring, counters and flags.

Test Plan:
- Blinker, WRAP=0, live (7,6),(7,7),(7,8), run=1:
  - advance 1 -> q has (6,7),(7,7),(8,7) only;
  - advance 2 -> original pattern, osc2=1, stable=0, gen_count=2.
- Block (0,0),(0,1),(1,0),(1,1), STABLE_N=16, AUTO_HALT=1, run held:
  - stable=1 and halted=1 on advance 16, gen_count=16;
  - 10 more run cycles -> gen_count stays 16, q unchanged.
- Edge wrap, live (15,0),(0,0),(1,0):
  - WRAP=1 -> after 1 advance q has only bits 15, 0 and 1 set;
  - WRAP=0 -> q=0 and all_dead=1.
- Step control: run=0, single-cycle step pulse -> exactly one generation, gen_count=1; run=1 with step=1 for one cycle -> one generation only.
- Load during run: load=1 with run=1 -> q=d next edge, gen_count=0, stable/osc2/halted cleared; advancing resumes the cycle after load drops.
- areset asserted between clock edges mid-run -> q=0, gen_count=0, all flags 0 before the next edge; GEN_W=4 blinker run for 20 advances -> gen_count saturates at 15.
